// File: rtl/slow_tick_counter_pkg.sv
// Shared encodings for the slow tick counter: counting modes, ping-pong direction,
// and a constant clog2 used to size the prescaler and debounce counters.
package slow_tick_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_SAT      = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/slow_tick_counter_prescaler.sv
// Single-clock prescaler: registered 1-cycle tick every (DIV >> speed) cycles, plus a
// blink output that toggles with each tick.
module tick_prescaler
  import slow_tick_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  output logic       tick,
  output logic       blink
);

  localparam int PW = clog2(DIV);
  localparam logic [PW:0] DIV_V = (PW+1)'(DIV);
  localparam logic [PW:0] ONE_W = (PW+1)'(1);

  logic [PW-1:0] pre_cnt;
  logic [PW:0]   lim_m1;
  logic          tc;

  // ">=" rather than "==" so a speed-up that leaves pre_cnt beyond the new limit
  // restarts the period immediately instead of running through a wrap.
  assign lim_m1 = (DIV_V >> speed) - ONE_W;
  assign tc     = ({1'b0, pre_cnt} >= lim_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
      blink   <= 1'b0;
    end else begin
      tick <= tc;
      if (tc) begin
        pre_cnt <= '0;
        blink   <= ~blink;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/slow_tick_counter.sv
// WIDTH-bit LED counter stepped by the prescaler tick, with four run-time modes and load.
// Optional debounced step button when SLOW_TICK_COUNTER_DEBOUNCE_EN is defined.
//
//   dir      | meaning
//   DIR_UP   | ping-pong climbing toward MAX (held here in all other modes)
//   DIR_DOWN | ping-pong descending toward 0
module slow_tick_counter
  import slow_tick_pkg::*;
#(
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_HZ = 2,
  parameter int WIDTH   = 6,
  parameter int DEB_MS  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             btn,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             blink,
  output logic             wrap
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DEB_RAW = DEB_MS * CLK_HZ / 1000;
  localparam int DEB_CYC = (DEB_RAW < 4) ? 4 : DEB_RAW;
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  dir_e  dir;
  mode_e mode_sel;
  logic  step;
  logic  btn_step;

  assign mode_sel = mode_e'(mode);

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .speed (speed),
    .tick  (tick),
    .blink (blink)
  );

`ifdef SLOW_TICK_COUNTER_DEBOUNCE_EN
  localparam int DW = clog2(DEB_CYC);
  localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYC - 1);

  logic [1:0]    btn_sync;
  logic          btn_stable;
  logic [DW-1:0] deb_cnt;

  // Stable level only follows the synchronised input after DEB_CYC unchanged cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync   <= 2'b00;
      btn_stable <= 1'b0;
      deb_cnt    <= DEB_LOAD;
      btn_step   <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], btn};
      btn_step <= 1'b0;
      if (btn_sync[1] == btn_stable) begin
        deb_cnt <= DEB_LOAD;
      end else if (deb_cnt == '0) begin
        btn_stable <= btn_sync[1];
        btn_step   <= btn_sync[1];
        deb_cnt    <= DEB_LOAD;
      end else begin
        deb_cnt <= deb_cnt - DW'(1);
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = btn & (DEB_CYC > 0);
  assign btn_step   = 1'b0;
`endif

  assign step = (tick & en) | btn_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      dir   <= DIR_UP;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (mode_sel != MODE_PINGPONG) dir <= DIR_UP;
      if (load) begin
        count <= load_val;
        dir   <= DIR_UP;
      end else if (step) begin
        case (mode_sel)
          MODE_UP: begin
            count <= count + ONE;
            wrap  <= (count == MAX);
          end
          MODE_DOWN: begin
            count <= count - ONE;
            wrap  <= (count == '0);
          end
          MODE_SAT: begin
            if (count != MAX) begin
              count <= count + ONE;
              wrap  <= (count == MAX - ONE);
            end
          end
          default: begin
            // An endpoint reached by load or mode change turns around without a wrap.
            if (dir == DIR_UP) begin
              if (count == MAX) begin
                count <= count - ONE;
                dir   <= DIR_DOWN;
              end else begin
                count <= count + ONE;
                if (count == MAX - ONE) begin
                  dir  <= DIR_DOWN;
                  wrap <= 1'b1;
                end
              end
            end else begin
              if (count == '0) begin
                count <= count + ONE;
                dir   <= DIR_UP;
              end else begin
                count <= count - ONE;
                if (count == ONE) begin
                  dir  <= DIR_UP;
                  wrap <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule
